// File: rtl/fetch_unit.sv
// fetch_unit: holds the PC, drives the instruction-memory read and buffers one word for the decoder.
// Latency: ihit in cycle t presents the word on o_instr in cycle t+1; one word per cycle back-to-back.
// Backpressure: i_stall with a held word drops o_imemren so the held word is never overwritten.
// Build option: define FETCH_PERF_EN to add the fetch/stall performance counters (else tied to 0).
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imemren,
    output logic [31:0] o_imemaddr,
    input  logic        i_ihit,
    input  logic [31:0] i_iload,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic [31:0] o_npc,
    output logic        o_instr_valid,
    output logic        o_halted,
    output logic [31:0] o_fetch_count,
    output logic [31:0] o_stall_count
);

    localparam logic [5:0] OP_HALT = 6'h3F;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_instr_valid;
    logic        w_imemren;
    logic        w_halted;
    logic        w_accept;
    logic        w_consume;
    logic        w_halt_word;

    // Request already excludes flush, so an accept is never overridden afterwards.
    assign w_accept    = w_imemren & i_ihit;
    assign w_consume   = r_instr_valid & ~i_stall;
    assign w_halt_word = (i_iload[31:26] == OP_HALT);

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: flush wins over HALT detection and over the HALT consume
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (w_accept && w_halt_word) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (i_flush) begin
                    w_state_nxt = S_RUN;
                end else if (w_consume) begin
                    w_state_nxt = S_HALTED;
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // FSM outputs: request only while running, buffer not blocked, no redirect and not in reset
    always_comb begin
        w_imemren = (r_state == S_RUN) && !(r_instr_valid && i_stall) && !i_flush && !i_rst;
        w_halted  = (r_state == S_HALTED);
    end

    // PC and one-entry output buffer; everything freezes once halted
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc          <= PC_INIT;
            r_instr       <= 32'h0;
            r_instr_pc    <= 32'h0;
            r_instr_valid <= 1'b0;
        end else if (r_state != S_HALTED) begin
            if (i_flush) begin
                r_instr_valid <= 1'b0;
                r_pc          <= i_redirect_pc & ~32'h0000_0003;
            end else if (w_accept) begin
                r_instr       <= i_iload;
                r_instr_pc    <= r_pc;
                r_instr_valid <= 1'b1;
                r_pc          <= r_pc + 32'd4;
            end else if (w_consume) begin
                r_instr_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    // Performance counters, wrap naturally, cleared only by reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fetch_count <= 32'h0;
            r_stall_count <= 32'h0;
        end else begin
            if (w_accept) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (r_instr_valid && i_stall) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign o_fetch_count = r_fetch_count;
    assign o_stall_count = r_stall_count;
`else
    assign o_fetch_count = 32'h0;
    assign o_stall_count = 32'h0;
`endif

    assign o_imemren     = w_imemren;
    assign o_imemaddr    = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_npc         = r_instr_pc + 32'd4;
    assign o_instr_valid = r_instr_valid;
    assign o_halted      = w_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a scoreboard of expected decoder-side words.
// Latency: expected words are queued up front and popped on every consume seen by the monitor.
// Backpressure: stall/flush are driven directly; a second instance covers the PC wrap and async reset.
module tb_fetch_unit;

`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic        clk;
    logic        rst, rst2;
    logic        ihit, ihit2;
    logic        stall, stall2;
    logic        flush;
    logic [31:0] redirect;
    logic        halt_en;
    logic [31:0] halt_addr;

    logic        imemren, imemren2;
    logic [31:0] imemaddr, imemaddr2;
    logic [31:0] iload, iload2;
    logic [31:0] instr, instr2, instr_pc, instr_pc2, npc, npc2;
    logic        instr_valid, instr_valid2, halted, halted2;
    logic [31:0] fetch_count, fetch_count2, stall_count, stall_count2;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t q[$];

    // Memory model: a distinct non-HALT word per address, HALT planted at halt_addr
    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h2A5A_0000;
    endfunction

    assign iload  = (halt_en && imemaddr == halt_addr) ? 32'hFFFF_FFFF : memf(imemaddr);
    assign iload2 = memf(imemaddr2);

    fetch_unit dut (
        .i_clk(clk), .i_rst(rst),
        .o_imemren(imemren), .o_imemaddr(imemaddr),
        .i_ihit(ihit), .i_iload(iload),
        .i_stall(stall), .i_flush(flush), .i_redirect_pc(redirect),
        .o_instr(instr), .o_instr_pc(instr_pc), .o_npc(npc),
        .o_instr_valid(instr_valid), .o_halted(halted),
        .o_fetch_count(fetch_count), .o_stall_count(stall_count)
    );

    fetch_unit #(.PC_INIT(32'hFFFF_FFFC)) dut2 (
        .i_clk(clk), .i_rst(rst2),
        .o_imemren(imemren2), .o_imemaddr(imemaddr2),
        .i_ihit(ihit2), .i_iload(iload2),
        .i_stall(stall2), .i_flush(1'b0), .i_redirect_pc(32'h0),
        .o_instr(instr2), .o_instr_pc(instr_pc2), .o_npc(npc2),
        .o_instr_valid(instr_valid2), .o_halted(halted2),
        .o_fetch_count(fetch_count2), .o_stall_count(stall_count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        e.instr = ins;
        e.pc    = pc;
        q.push_back(e);
    endtask

    // Monitor: every word the decoder actually takes must match the next expected entry
    always @(negedge clk) begin
        if (!rst && instr_valid && !stall && !flush) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got pc %h instr %h, expected no word", instr_pc, instr);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_instr", instr, e.instr);
                chk("sb_pc", instr_pc, e.pc);
                chk("sb_npc", npc, e.pc + 32'd4);
            end
        end
    end

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        ihit = 1'b1; ihit2 = 1'b1;
        stall = 1'b0; stall2 = 1'b0;
        flush = 1'b0; redirect = 32'h0;
        halt_en = 1'b1; halt_addr = 32'h20;

        // Reset state
        @(negedge clk);
        chk("rst_ren", imemren, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_addr", imemaddr, 32'h0);
        chk("rst_fcnt", fetch_count, 0);
        chk("rst_scnt", stall_count, 0);

        // Streaming fetch with zero-wait memory
        push(memf(32'h0), 32'h0);
        push(memf(32'h4), 32'h4);
        push(memf(32'h8), 32'h8);
        step(); rst = 1'b0; @(negedge clk);
        chk("t1_addr0", imemaddr, 32'h0);
        chk("t1_ren", imemren, 1);
        chk("t1_valid0", instr_valid, 0);
        step(); @(negedge clk);
        chk("t1_addr4", imemaddr, 32'h4);
        chk("t1_pc0", instr_pc, 32'h0);
        chk("t1_valid1", instr_valid, 1);
        step(); @(negedge clk);
        chk("t1_addr8", imemaddr, 32'h8);
        chk("t1_pc4", instr_pc, 32'h4);

        // Stall three cycles with pc 8 held
        step(); stall = 1'b1; @(negedge clk);
        chk("t2_ren", imemren, 0);
        chk("t2_pc8", instr_pc, 32'h8);
        for (int i = 0; i < 2; i++) begin
            step(); @(negedge clk);
            chk("t2_hold_instr", instr, memf(32'h8));
            chk("t2_hold_ren", imemren, 0);
        end
        step(); stall = 1'b0; @(negedge clk);
        chk("t2_scnt", stall_count, PERF ? 32'd3 : 32'd0);
        chk("t2_fcnt", fetch_count, PERF ? 32'd3 : 32'd0);
        chk("t2_addr12", imemaddr, 32'hC);
        chk("t2_ren_back", imemren, 1);

        // Redirect in the same cycle as ihit
        step(); flush = 1'b1; redirect = 32'h0000_0103; @(negedge clk);
        chk("t3_ren_flush", imemren, 0);
        chk("t3_pc12", instr_pc, 32'hC);
        push(memf(32'h100), 32'h100);
        step(); flush = 1'b0; @(negedge clk);
        chk("t3_valid0", instr_valid, 0);
        chk("t3_addr100", imemaddr, 32'h100);
        chk("t3_ren", imemren, 1);
        step(); @(negedge clk);
        chk("t3_pc100", instr_pc, 32'h100);

        // Redirect to 0x1C so the HALT at 0x20 is fetched next
        step(); flush = 1'b1; redirect = 32'h1C; @(negedge clk);
        push(memf(32'h1C), 32'h1C);
        push(32'hFFFF_FFFF, 32'h20);
        step(); flush = 1'b0; @(negedge clk);
        chk("t4_addr1c", imemaddr, 32'h1C);
        step(); @(negedge clk);
        chk("t4_addr20", imemaddr, 32'h20);
        step(); @(negedge clk);
        chk("t4_halt_instr", instr, 32'hFFFF_FFFF);
        chk("t4_drain_ren", imemren, 0);
        chk("t4_not_yet", halted, 0);
        step(); @(negedge clk);
        chk("t4_halted", halted, 1);
        chk("t4_valid0", instr_valid, 0);
        chk("t4_ren0", imemren, 0);
        step(); flush = 1'b1; redirect = 32'h0; @(negedge clk);
        chk("t4_flush_ren", imemren, 0);
        step(); flush = 1'b0; @(negedge clk);
        chk("t4_still_halted", halted, 1);
        chk("t4_still_ren0", imemren, 0);
        chk("t4_fcnt", fetch_count, PERF ? 32'd8 : 32'd0);

        // Wrong-path HALT cancelled by flush while draining
        step(); rst = 1'b1; halt_addr = 32'h0; @(negedge clk);
        chk("t5_rst_halted", halted, 0);
        chk("t5_rst_valid", instr_valid, 0);
        step(); rst = 1'b0; @(negedge clk);
        chk("t5_addr0", imemaddr, 32'h0);
        step(); stall = 1'b1; @(negedge clk);
        chk("t5_halt_held", instr, 32'hFFFF_FFFF);
        chk("t5_valid1", instr_valid, 1);
        chk("t5_ren0", imemren, 0);
        step(); flush = 1'b1; redirect = 32'h40; halt_en = 1'b0; @(negedge clk);
        chk("t5_flush_ren", imemren, 0);
        push(memf(32'h40), 32'h40);
        push(memf(32'h44), 32'h44);
        push(memf(32'h48), 32'h48);
        step(); flush = 1'b0; @(negedge clk);
        chk("t5_valid0", instr_valid, 0);
        chk("t5_not_halted", halted, 0);
        chk("t5_addr40", imemaddr, 32'h40);
        chk("t5_empty_stall_ren", imemren, 1);
        step(); stall = 1'b0; @(negedge clk);
        chk("t5_pc40", instr_pc, 32'h40);
        step(); ihit = 1'b0; @(negedge clk);
        chk("t5_pc44", instr_pc, 32'h44);
        chk("t5_addr48", imemaddr, 32'h48);
        step(); ihit = 1'b1; @(negedge clk);
        chk("t5_miss_valid0", instr_valid, 0);
        chk("t5_miss_addr48", imemaddr, 32'h48);
        step(); ihit = 1'b0; @(negedge clk);
        chk("t5_pc48", instr_pc, 32'h48);
        step(); @(negedge clk);
        chk("t5_idle_valid0", instr_valid, 0);

        // PC wrap from PC_INIT = FFFF_FFFC, then async reset during a stall
        step(); rst2 = 1'b0; @(negedge clk);
        chk("t6_addr_init", imemaddr2, 32'hFFFF_FFFC);
        step(); @(negedge clk);
        chk("t6_pc_init", instr_pc2, 32'hFFFF_FFFC);
        chk("t6_npc_wrap", npc2, 32'h0);
        chk("t6_addr_wrap", imemaddr2, 32'h0);
        step(); stall2 = 1'b1; @(negedge clk);
        chk("t6_pc0", instr_pc2, 32'h0);
        chk("t6_instr0", instr2, memf(32'h0));
        chk("t6_stall_ren", imemren2, 0);
        step(); #2; rst2 = 1'b1; #1;
        chk("t6_arst_ren", imemren2, 0);
        chk("t6_arst_valid", instr_valid2, 0);
        chk("t6_arst_instr", instr2, 0);
        chk("t6_arst_pc", instr_pc2, 0);
        chk("t6_arst_npc", npc2, 32'h4);
        chk("t6_arst_addr", imemaddr2, 32'hFFFF_FFFC);
        chk("t6_arst_halted", halted2, 0);
        chk("t6_arst_fcnt", fetch_count2, 0);
        chk("t6_arst_scnt", stall_count2, 0);

        step();
        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
